// File: rtl/pipeline_control.sv
// pipeline_control
//   Central sequencing block for the 5-stage MIPS pipeline. Merges the stage
//   stall requests into one stall vector, arbitrates PC redirects (exception /
//   ERET over branch), raises flush on exceptions, inserts fetch penalty
//   cycles after every accepted redirect and keeps two saturating
//   performance counters.
//
// Ports
//   clock, reset              system clock, synchronous active-high reset
//   stall_request_id/ex/mem   per-stage hazard / busy requests
//   branch_taken, branch_target   branch redirect from ID
//   exception_valid, exception_is_eret, cp0_epc   exception redirect from MEM
//   stall[5:0]                hold vector: 0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB
//   flush                     clear all pipeline registers
//   register_pc_write_enable/_data   PC register write port
//   stall_cycles, flush_count saturating performance counters
module pipeline_control #(
    parameter logic [31:0] EXCEPTION_VECTOR = 32'h00000020,
    parameter int unsigned REDIRECT_PENALTY = 1,
    parameter int unsigned COUNTER_WIDTH    = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall_request_id,
    input  logic                     stall_request_ex,
    input  logic                     stall_request_mem,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     exception_valid,
    input  logic                     exception_is_eret,
    input  logic [31:0]              cp0_epc,
    output logic [5:0]               stall,
    output logic                     flush,
    output logic                     register_pc_write_enable,
    output logic [31:0]              register_pc_write_data,
    output logic [COUNTER_WIDTH-1:0] stall_cycles,
    output logic [COUNTER_WIDTH-1:0] flush_count
);

    localparam logic [3:0] PENALTY_LOAD = 4'(REDIRECT_PENALTY);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_ONE = COUNTER_WIDTH'(1);

    logic [3:0]               penalty_q, penalty_d;
    logic [COUNTER_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
    logic [COUNTER_WIDTH-1:0] flush_count_q, flush_count_d;
    logic                     redirect_accepted;

    // Stall priority and redirect arbitration. All outputs are forced low
    // while reset is held, regardless of the request inputs.
    always_comb begin
        stall                    = 6'b000000;
        flush                    = 1'b0;
        register_pc_write_enable = 1'b0;
        register_pc_write_data   = 32'h0;
        if (!reset) begin
            if (exception_valid) begin
                // Exception owns the cycle: no stall, branch ignored.
                flush                    = 1'b1;
                register_pc_write_enable = 1'b1;
                register_pc_write_data   = exception_is_eret ? cp0_epc : EXCEPTION_VECTOR;
            end else begin
                if (stall_request_mem)      stall = 6'b011111;
                else if (stall_request_ex)  stall = 6'b001111;
                else if (stall_request_id)  stall = 6'b000111;
                else if (penalty_q != 4'd0) stall = 6'b000011;
                // Enable is presented even while the PC is held; the PC
                // register itself qualifies it with stall[0].
                if (branch_taken) begin
                    register_pc_write_enable = 1'b1;
                    register_pc_write_data   = branch_target;
                end
            end
        end
    end

    // During an exception stall is all-zero, so exceptions always pass here.
    assign redirect_accepted = register_pc_write_enable && !stall[0];

    always_comb begin
        penalty_d = penalty_q;
        if (redirect_accepted) begin
            penalty_d = PENALTY_LOAD;
        end else if ((penalty_q != 4'd0) && !stall[2]) begin
            // Frozen while ID or any later stage is held.
            penalty_d = penalty_q - 4'd1;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if ((stall != 6'b000000) && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + COUNT_ONE;
        end
        if (flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + COUNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            penalty_q      <= 4'd0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            penalty_q      <= penalty_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    // Counters read as zero for the whole reset window, including the
    // first cycle before the synchronous clear has taken effect.
    assign stall_cycles = reset ? '0 : stall_cycles_q;
    assign flush_count  = reset ? '0 : flush_count_q;

endmodule

// File: tb/tb_pipeline_control.sv
module tb_pipeline_control;

    localparam int          CW  = 4;
    localparam int          PEN = 1;
    localparam logic [31:0] EV  = 32'h00000020;
    localparam int          SAT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall_request_id, stall_request_ex, stall_request_mem;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          exception_valid, exception_is_eret;
    logic [31:0]   cp0_epc;
    logic [5:0]    stall;
    logic          flush;
    logic          register_pc_write_enable;
    logic [31:0]   register_pc_write_data;
    logic [CW-1:0] stall_cycles, flush_count;

    pipeline_control #(
        .EXCEPTION_VECTOR(EV),
        .REDIRECT_PENALTY(PEN),
        .COUNTER_WIDTH   (CW)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .stall_request_id        (stall_request_id),
        .stall_request_ex        (stall_request_ex),
        .stall_request_mem       (stall_request_mem),
        .branch_taken            (branch_taken),
        .branch_target           (branch_target),
        .exception_valid         (exception_valid),
        .exception_is_eret       (exception_is_eret),
        .cp0_epc                 (cp0_epc),
        .stall                   (stall),
        .flush                   (flush),
        .register_pc_write_enable(register_pc_write_enable),
        .register_pc_write_data  (register_pc_write_data),
        .stall_cycles            (stall_cycles),
        .flush_count             (flush_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: remaining penalty cycles and counter values.
    int m_pen = 0;
    int m_sc  = 0;
    int m_fc  = 0;

    logic [5:0]  e_stall;
    logic        e_flush, e_we;
    logic [31:0] e_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Stall pattern expressed as "how many low-order stages are held".
    task automatic model_outputs();
        int held;
        held    = 0;
        e_flush = 1'b0;
        e_we    = 1'b0;
        e_data  = 32'h0;
        if (!reset) begin
            if (exception_valid) begin
                held    = 0;
                e_flush = 1'b1;
                e_we    = 1'b1;
                e_data  = exception_is_eret ? cp0_epc : EV;
            end else begin
                if (stall_request_mem)     held = 5;
                else if (stall_request_ex) held = 4;
                else if (stall_request_id) held = 3;
                else if (m_pen > 0)        held = 2;
                if (branch_taken) begin
                    e_we   = 1'b1;
                    e_data = branch_target;
                end
            end
        end
        e_stall = 6'((32'd1 << held) - 32'd1);
    endtask

    task automatic model_update();
        bit accepted;
        if (reset) begin
            m_pen = 0;
            m_sc  = 0;
            m_fc  = 0;
        end else begin
            accepted = e_we && (exception_valid || !e_stall[0]);
            if (accepted)                     m_pen = PEN;
            else if (m_pen > 0 && !e_stall[2]) m_pen = m_pen - 1;
            if (e_stall != 0 && m_sc < SAT) m_sc++;
            if (e_flush && m_fc < SAT)      m_fc++;
        end
    endtask

    // One clock: compare all outputs mid-cycle, then advance the model.
    task automatic tick();
        @(negedge clock);
        model_outputs();
        check("stall",    32'(stall),                    32'(e_stall));
        check("flush",    32'(flush),                    32'(e_flush));
        check("pc_we",    32'(register_pc_write_enable), 32'(e_we));
        check("pc_data",  register_pc_write_data,        e_data);
        check("stall_cy", 32'(stall_cycles),             reset ? 32'd0 : 32'(m_sc));
        check("flush_ct", 32'(flush_count),              reset ? 32'd0 : 32'(m_fc));
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        stall_request_id  = 1'b0;
        stall_request_ex  = 1'b0;
        stall_request_mem = 1'b0;
        branch_taken      = 1'b0;
        branch_target     = 32'h0;
        exception_valid   = 1'b0;
        exception_is_eret = 1'b0;
        cp0_epc           = 32'h0;
    endtask

    initial begin
        // Reset with every stall request high.
        idle_inputs();
        reset             = 1'b1;
        stall_request_id  = 1'b1;
        stall_request_ex  = 1'b1;
        stall_request_mem = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("mem_after_reset", 32'(stall), 32'h1F);
        tick();

        // Short reset mid-stall, then an ID hazard for 3 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        stall_request_id = 1'b1;
        repeat (3) begin
            #1;
            check("id_pattern", 32'(stall), 32'h07);
            tick();
        end
        stall_request_id = 1'b0;
        #1;
        check("id_count", 32'(stall_cycles), 32'd3);
        tick();

        // Branch with no stalls: one penalty cycle afterwards.
        branch_taken  = 1'b1;
        branch_target = 32'h00400100;
        #1;
        check("br_data", register_pc_write_data, 32'h00400100);
        tick();
        idle_inputs();
        #1;
        check("br_penalty", 32'(stall), 32'h03);
        tick();
        check("br_done", 32'(stall), 32'h00);
        tick();

        // Branch held behind an EX stall, then accepted when EX drops.
        branch_taken     = 1'b1;
        branch_target    = 32'h00400200;
        stall_request_ex = 1'b1;
        tick();
        tick();
        stall_request_ex = 1'b0;
        tick();
        idle_inputs();
        #1;
        check("brex_penalty", 32'(stall), 32'h03);
        tick();
        tick();

        // Exceptions override a MEM stall; back-to-back flushes.
        exception_valid   = 1'b1;
        stall_request_mem = 1'b1;
        branch_taken      = 1'b1;
        branch_target     = 32'h12345678;
        #1;
        check("exc_data", register_pc_write_data, 32'h00000020);
        tick();
        exception_is_eret = 1'b1;
        cp0_epc           = 32'h80001234;
        #1;
        check("eret_data", register_pc_write_data, 32'h80001234);
        check("fc_one", 32'(flush_count), 32'd1);
        tick();
        idle_inputs();
        #1;
        check("fc_two", 32'(flush_count), 32'd2);
        tick();

        // Saturate the 4-bit stall counter.
        stall_request_mem = 1'b1;
        repeat (20) tick();
        check("sc_sat", 32'(stall_cycles), 32'(SAT));
        idle_inputs();
        tick();

        // Randomized traffic including occasional resets.
        repeat (400) begin
            reset             = ($urandom_range(0, 99) < 3);
            stall_request_id  = ($urandom_range(0, 99) < 20);
            stall_request_ex  = ($urandom_range(0, 99) < 15);
            stall_request_mem = ($urandom_range(0, 99) < 15);
            branch_taken      = ($urandom_range(0, 99) < 30);
            branch_target     = $urandom;
            exception_valid   = ($urandom_range(0, 99) < 8);
            exception_is_eret = $urandom_range(0, 1) == 1;
            cp0_epc           = $urandom;
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
